// File: rtl/bram_stream_writer.sv
// Valid/ready stream of sample words into BRAM port A as a circular buffer, with full backpressure.
// Defining BRAM_WRITER_DROP_EN adds drop_count; words that arrive while full are then accepted and discarded.
module bram_stream_writer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 8192,
  parameter int BLOCK_WORDS = 512,
  parameter int PTR_WIDTH   = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PTR_WIDTH-1:0]  rd_ptr,
  output logic                  porta_en,
  output logic [7:0]            porta_we,
  output logic [ADDR_WIDTH-1:0] porta_addr,
  output logic [DATA_WIDTH-1:0] porta_din,
  output logic [PTR_WIDTH-1:0]  wr_ptr,
  output logic [PTR_WIDTH-1:0]  occupancy,
`ifdef BRAM_WRITER_DROP_EN
  output logic [31:0]           drop_count,
`endif
  output logic                  block_done,
  output logic                  ptr_err
);

  localparam int                   IDX_W    = PTR_WIDTH - 1;
  localparam logic [PTR_WIDTH-1:0] DEPTH_P  = PTR_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] BLK_MASK = PTR_WIDTH'(BLOCK_WORDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [PTR_WIDTH-1:0]  rd_q, rd_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, wr_inc;
  logic [PTR_WIDTH-1:0]  occ_q, occ_d;
  logic                  ptr_err_q, ptr_err_d;
  logic                  porta_en_q, porta_en_d;
  logic [ADDR_WIDTH-1:0] porta_addr_q, porta_addr_d;
  logic [DATA_WIDTH-1:0] porta_din_q, porta_din_d;
  logic                  block_done_q, block_done_d;
  logic                  full, fire, wr_en;

  // Occupancy is registered against the previous rd_q, so full can only lag a read, never a write.
  assign full = (occ_q >= DEPTH_P);

`ifdef BRAM_WRITER_DROP_EN
  assign s_ready = (state_q == RUN) && enable && !clear;
`else
  assign s_ready = (state_q == RUN) && enable && !clear && !full;
`endif

  assign fire   = s_valid && s_ready;
  assign wr_en  = fire && !full;
  assign wr_inc = wr_ptr_q + PTR_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable)  state_d = RUN;
        RUN:     if (!enable) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_d         = rd_ptr;
    wr_ptr_d     = wr_ptr_q;
    porta_en_d   = 1'b0;
    porta_addr_d = porta_addr_q;
    porta_din_d  = porta_din_q;
    block_done_d = 1'b0;
    ptr_err_d    = ptr_err_q | (occ_q > DEPTH_P);
    if (wr_en) begin
      porta_en_d   = 1'b1;
      porta_addr_d = ADDR_WIDTH'({wr_ptr_q[IDX_W-1:0], 3'b000});
      porta_din_d  = s_data;
      wr_ptr_d     = wr_inc;
      block_done_d = ((wr_inc & BLK_MASK) == '0);
    end
    occ_d = wr_ptr_d - rd_q;
    if (clear) begin
      wr_ptr_d  = '0;
      occ_d     = '0;
      ptr_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_q         <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      ptr_err_q    <= 1'b0;
      porta_en_q   <= 1'b0;
      porta_addr_q <= '0;
      porta_din_q  <= '0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
      ptr_err_q    <= ptr_err_d;
      porta_en_q   <= porta_en_d;
      porta_addr_q <= porta_addr_d;
      porta_din_q  <= porta_din_d;
      block_done_q <= block_done_d;
    end
  end

`ifdef BRAM_WRITER_DROP_EN
  logic [31:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (clear) begin
      drop_count_d = '0;
    end else if (fire && full && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) drop_count_q <= '0;
    else     drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`endif

  assign porta_en   = porta_en_q;
  assign porta_we   = {8{porta_en_q}};
  assign porta_addr = porta_addr_q;
  assign porta_din  = porta_din_q;
  assign wr_ptr     = wr_ptr_q;
  assign occupancy  = occ_q;
  assign block_done = block_done_q;
  assign ptr_err    = ptr_err_q;

endmodule

// File: tb/tb_bram_stream_writer.sv
// Bench for bram_stream_writer at DEPTH=16, BLOCK_WORDS=4, with a word-count reference model.
// Build with BRAM_WRITER_DROP_EN defined to exercise the drop variant.
module tb_bram_stream_writer;
  localparam int DEPTH       = 16;
  localparam int BLOCK_WORDS = 4;
  localparam int ADDR_WIDTH  = 16;
  localparam int DATA_WIDTH  = 64;
  localparam int PTR_W       = $clog2(DEPTH) + 1;
  localparam int PMOD        = 2 * DEPTH;

  logic                  clk = 1'b0;
  logic                  rst, enable, clear, s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  s_ready, porta_en, block_done, ptr_err;
  logic [7:0]            porta_we;
  logic [ADDR_WIDTH-1:0] porta_addr;
  logic [DATA_WIDTH-1:0] porta_din;
  logic [PTR_W-1:0]      wr_ptr, occupancy;
`ifdef BRAM_WRITER_DROP_EN
  logic [31:0]           drop_count;
`endif

  always #5 clk = ~clk;

  bram_stream_writer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .BLOCK_WORDS(BLOCK_WORDS),
    .PTR_WIDTH  (PTR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clear     (clear),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .rd_ptr    (rd_ptr),
    .porta_en  (porta_en),
    .porta_we  (porta_we),
    .porta_addr(porta_addr),
    .porta_din (porta_din),
    .wr_ptr    (wr_ptr),
    .occupancy (occupancy),
`ifdef BRAM_WRITER_DROP_EN
    .drop_count(drop_count),
`endif
    .block_done(block_done),
    .ptr_err   (ptr_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: word counts and the software pointer as the block has seen it.
  int unsigned           m_wr, m_rd_q, m_occ, m_drops;
  bit                    m_run, m_err;
  bit                    exp_ready, obs_ready, exp_en, exp_bd;
  logic [ADDR_WIDTH-1:0] exp_addr;
  logic [DATA_WIDTH-1:0] exp_din;

  task automatic model_reset();
    m_wr = 0; m_rd_q = 0; m_occ = 0; m_drops = 0; m_run = 0; m_err = 0;
    exp_en = 0; exp_bd = 0; exp_addr = '0; exp_din = '0;
  endtask

  // One clock cycle: apply inputs, sample s_ready before the edge, advance the model, land 1 after the edge.
  task automatic drive(input bit en, input bit clr, input bit v, input logic [DATA_WIDTH-1:0] d,
                       input int unsigned rp);
    bit full, hs, wr;
    enable = en; clear = clr; s_valid = v; s_data = d; rd_ptr = PTR_W'(rp);
    full = (m_occ >= DEPTH);
`ifdef BRAM_WRITER_DROP_EN
    exp_ready = m_run && en && !clr;
`else
    exp_ready = m_run && en && !clr && !full;
`endif
    #1 obs_ready = s_ready;
    hs = v && exp_ready;
    wr = hs && !full;
    exp_en = wr;
    exp_bd = 0;
    if (wr) begin
      exp_addr = ADDR_WIDTH'((m_wr % DEPTH) * 8);
      exp_din  = d;
    end
    if (clr) begin
      m_wr = 0; m_occ = 0; m_err = 0; m_drops = 0;
    end else begin
      if (m_occ > DEPTH) m_err = 1;
      if (wr) begin
        m_wr   = (m_wr + 1) % PMOD;
        exp_bd = (m_wr % BLOCK_WORDS) == 0;
      end
      if (hs && full && m_drops != 32'hFFFF_FFFF) m_drops++;
      m_occ = (m_wr + PMOD - m_rd_q) % PMOD;
    end
    m_run  = en && !clr;
    m_rd_q = rp % PMOD;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    drive(1, 1, 0, '0, 0);
    drive(1, 0, 0, '0, 0);
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; clear = 0; s_valid = 0; s_data = '0; rd_ptr = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL reset_s_ready got=%0h want=0", s_ready); end
    total++; if (porta_en !== 1'b0)  begin bad++; $display("FAIL reset_porta_en got=%0h want=0", porta_en); end
    total++; if (porta_we !== 8'h00) begin bad++; $display("FAIL reset_porta_we got=%0h want=0", porta_we); end
    total++; if (porta_addr !== '0)  begin bad++; $display("FAIL reset_porta_addr got=%0h want=0", porta_addr); end
    total++; if (porta_din !== '0)   begin bad++; $display("FAIL reset_porta_din got=%0h want=0", porta_din); end
    total++; if (wr_ptr !== '0)      begin bad++; $display("FAIL reset_wr_ptr got=%0h want=0", wr_ptr); end
    total++; if (occupancy !== '0)   begin bad++; $display("FAIL reset_occupancy got=%0h want=0", occupancy); end
    total++; if (block_done !== 1'b0) begin bad++; $display("FAIL reset_block_done got=%0h want=0", block_done); end
    total++; if (ptr_err !== 1'b0)   begin bad++; $display("FAIL reset_ptr_err got=%0h want=0", ptr_err); end
`ifdef BRAM_WRITER_DROP_EN
    total++; if (drop_count !== '0)  begin bad++; $display("FAIL reset_drop_count got=%0h want=0", drop_count); end
`endif
    rst = 0;
    model_reset();
  endtask

  task automatic test_basic();
    drive(1, 0, 0, '0, 0);
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL basic_idle_ready got=%0h want=0", obs_ready); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 64'(32'h1000 + i), 0);
      total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL basic_ready[%0d] got=%0h want=1", i, obs_ready); end
      total++; if (porta_en !== 1'b1 || porta_we !== 8'hFF)
        begin bad++; $display("FAIL basic_en_we[%0d] got=%0h/%0h want=1/ff", i, porta_en, porta_we); end
      total++; if (porta_addr !== 16'(i * 8))
        begin bad++; $display("FAIL basic_addr[%0d] got=%0h want=%0h", i, porta_addr, i * 8); end
      total++; if (porta_din !== 64'(32'h1000 + i))
        begin bad++; $display("FAIL basic_din[%0d] got=%0h want=%0h", i, porta_din, 32'h1000 + i); end
    end
    drive(1, 0, 0, '0, 0);
    total++; if (porta_en !== 1'b0 || porta_we !== 8'h00)
      begin bad++; $display("FAIL basic_idle_write got=%0h/%0h want=0/0", porta_en, porta_we); end
    total++; if (wr_ptr !== 5'd3)    begin bad++; $display("FAIL basic_wr_ptr got=%0d want=3", wr_ptr); end
    total++; if (occupancy !== 5'd3) begin bad++; $display("FAIL basic_occupancy got=%0d want=3", occupancy); end
  endtask

  task automatic test_block_done();
    int pulses;
    int pulse_wr;
    pulses = 0; pulse_wr = -1;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, (i < 4), {$urandom, $urandom}, 0);
      total++; if (block_done !== exp_bd)
        begin bad++; $display("FAIL block_done[%0d] got=%0h want=%0h", i, block_done, exp_bd); end
      if (block_done === 1'b1) begin pulses++; pulse_wr = int'(wr_ptr); end
    end
    total++; if (pulses != 1)   begin bad++; $display("FAIL block_pulses got=%0d want=1", pulses); end
    total++; if (pulse_wr != 4) begin bad++; $display("FAIL block_pulse_wr got=%0d want=4", pulse_wr); end
  endtask

`ifndef BRAM_WRITER_DROP_EN
  task automatic test_full();
    int writes;
    writes = 0;
    do_clear();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, {$urandom, $urandom}, 0);
      total++; if (obs_ready !== exp_ready)
        begin bad++; $display("FAIL full_ready[%0d] got=%0h want=%0h", i, obs_ready, exp_ready); end
      if (porta_en === 1'b1) writes++;
    end
    total++; if (writes != 16)        begin bad++; $display("FAIL full_writes got=%0d want=16", writes); end
    total++; if (wr_ptr !== 5'd16)    begin bad++; $display("FAIL full_wr_ptr got=%0d want=16", wr_ptr); end
    total++; if (obs_ready !== 1'b0)  begin bad++; $display("FAIL full_ready_low got=%0h want=0", obs_ready); end
    drive(1, 0, 1, 64'hA, 4);
    total++; if (obs_ready !== 1'b0)  begin bad++; $display("FAIL full_rd_lag1 got=%0h want=0", obs_ready); end
    drive(1, 0, 1, 64'hB, 4);
    total++; if (obs_ready !== 1'b0)  begin bad++; $display("FAIL full_rd_lag2 got=%0h want=0", obs_ready); end
    drive(1, 0, 1, 64'hC, 4);
    total++; if (obs_ready !== 1'b1)  begin bad++; $display("FAIL full_reassert got=%0h want=1", obs_ready); end
    total++; if (porta_en !== 1'b1 || porta_addr !== 16'h0000)
      begin bad++; $display("FAIL full_wrap_write got=%0h@%0h want=1@0", porta_en, porta_addr); end
    total++; if (porta_din !== 64'hC) begin bad++; $display("FAIL full_wrap_din got=%0h want=c", porta_din); end
    total++; if (wr_ptr !== 5'd17)    begin bad++; $display("FAIL full_wr_ptr17 got=%0d want=17", wr_ptr); end
    total++; if (occupancy !== 5'd13) begin bad++; $display("FAIL full_occupancy got=%0d want=13", occupancy); end
  endtask
`else
  task automatic test_drop();
    do_clear();
    for (int i = 0; i < 16; i++) drive(1, 0, 1, {$urandom, $urandom}, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, {$urandom, $urandom}, 0);
      total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL drop_ready[%0d] got=%0h want=1", i, obs_ready); end
      total++; if (porta_en !== 1'b0)  begin bad++; $display("FAIL drop_write[%0d] got=%0h want=0", i, porta_en); end
    end
    total++; if (drop_count !== 32'd3) begin bad++; $display("FAIL drop_count got=%0d want=3", drop_count); end
    total++; if (wr_ptr !== 5'd16)     begin bad++; $display("FAIL drop_wr_ptr got=%0d want=16", wr_ptr); end
    do_clear();
    total++; if (drop_count !== '0)    begin bad++; $display("FAIL drop_clear got=%0d want=0", drop_count); end
  endtask
`endif

  task automatic test_ptr_err();
    do_clear();
    drive(1, 0, 1, {$urandom, $urandom}, 0);
    drive(1, 0, 1, {$urandom, $urandom}, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, '0, 8);
    total++; if (ptr_err !== 1'b1)     begin bad++; $display("FAIL ptr_err_set got=%0h want=1", ptr_err); end
    total++; if (occupancy !== 5'd26)  begin bad++; $display("FAIL ptr_err_occ got=%0d want=26", occupancy); end
    drive(1, 0, 1, {$urandom, $urandom}, 8);
`ifdef BRAM_WRITER_DROP_EN
    total++; if (obs_ready !== 1'b1)   begin bad++; $display("FAIL ptr_err_ready got=%0h want=1", obs_ready); end
`else
    total++; if (obs_ready !== 1'b0)   begin bad++; $display("FAIL ptr_err_ready got=%0h want=0", obs_ready); end
`endif
    total++; if (porta_en !== 1'b0)    begin bad++; $display("FAIL ptr_err_nowrite got=%0h want=0", porta_en); end
    for (int i = 0; i < 4; i++) drive(1, 0, 0, '0, 2);
    total++; if (ptr_err !== 1'b1)     begin bad++; $display("FAIL ptr_err_sticky got=%0h want=1", ptr_err); end
    total++; if (occupancy !== 5'd0)   begin bad++; $display("FAIL ptr_err_occ0 got=%0d want=0", occupancy); end
    drive(1, 1, 0, '0, 0);
    total++; if (ptr_err !== 1'b0)     begin bad++; $display("FAIL ptr_err_clear got=%0h want=0", ptr_err); end
    total++; if (wr_ptr !== '0)        begin bad++; $display("FAIL ptr_err_wr_clear got=%0d want=0", wr_ptr); end
  endtask

  task automatic test_clear_handshake();
    do_clear();
    drive(1, 0, 1, 64'h55, 0);
    drive(1, 1, 1, 64'h66, 0);
    total++; if (obs_ready !== 1'b0)   begin bad++; $display("FAIL clr_hs_ready got=%0h want=0", obs_ready); end
    total++; if (porta_en !== 1'b0)    begin bad++; $display("FAIL clr_hs_write got=%0h want=0", porta_en); end
    total++; if (wr_ptr !== '0)        begin bad++; $display("FAIL clr_hs_wr_ptr got=%0d want=0", wr_ptr); end
    drive(1, 0, 1, 64'h77, 0);
    total++; if (obs_ready !== 1'b0)   begin bad++; $display("FAIL clr_hs_idle got=%0h want=0", obs_ready); end
    total++; if (porta_en !== 1'b0)    begin bad++; $display("FAIL clr_hs_idle_write got=%0h want=0", porta_en); end
  endtask

  task automatic test_rst_mid();
    do_clear();
    drive(1, 0, 1, {$urandom, $urandom}, 0);
    drive(1, 0, 1, {$urandom, $urandom}, 0);
    rst = 1; enable = 1; clear = 0; s_valid = 1;
    @(posedge clk);
    #1;
    total++; if (porta_en !== 1'b0 || porta_we !== 8'h00)
      begin bad++; $display("FAIL rst_mid_write got=%0h/%0h want=0/0", porta_en, porta_we); end
    total++; if (wr_ptr !== '0 || occupancy !== '0)
      begin bad++; $display("FAIL rst_mid_ptrs got=%0d/%0d want=0/0", wr_ptr, occupancy); end
    total++; if (s_ready !== 1'b0)     begin bad++; $display("FAIL rst_mid_ready got=%0h want=0", s_ready); end
    rst = 0; s_valid = 0; enable = 0;
    model_reset();
  endtask

  task automatic test_random();
    int unsigned sw_rd, avail;
    bit en, clr, v;
    do_clear();
    sw_rd = 0;
    for (int c = 0; c < 400; c++) begin
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 3) != 0);
      avail = (m_wr + PMOD - sw_rd) % PMOD;
      if ($urandom_range(0, 2) == 0) sw_rd = (sw_rd + $urandom_range(0, avail)) % PMOD;
      if (clr) sw_rd = 0;
      drive(en, clr, v, {$urandom, $urandom}, sw_rd);
      total++; if (obs_ready !== exp_ready)
        begin bad++; $display("FAIL rnd_ready[%0d] got=%0h want=%0h", c, obs_ready, exp_ready); end
      total++; if (porta_en !== exp_en || porta_we !== (exp_en ? 8'hFF : 8'h00))
        begin bad++; $display("FAIL rnd_en_we[%0d] got=%0h/%0h want=%0h", c, porta_en, porta_we, exp_en); end
      if (exp_en) begin
        total++; if (porta_addr !== exp_addr || porta_din !== exp_din)
          begin bad++; $display("FAIL rnd_write[%0d] got=%0h:%0h want=%0h:%0h", c, porta_addr, porta_din, exp_addr, exp_din); end
      end
      total++; if (wr_ptr !== PTR_W'(m_wr))
        begin bad++; $display("FAIL rnd_wr_ptr[%0d] got=%0d want=%0d", c, wr_ptr, m_wr); end
      total++; if (occupancy !== PTR_W'(m_occ))
        begin bad++; $display("FAIL rnd_occ[%0d] got=%0d want=%0d", c, occupancy, m_occ); end
      total++; if (block_done !== exp_bd)
        begin bad++; $display("FAIL rnd_block_done[%0d] got=%0h want=%0h", c, block_done, exp_bd); end
      total++; if (ptr_err !== m_err)
        begin bad++; $display("FAIL rnd_ptr_err[%0d] got=%0h want=%0h", c, ptr_err, m_err); end
`ifdef BRAM_WRITER_DROP_EN
      total++; if (drop_count !== m_drops)
        begin bad++; $display("FAIL rnd_drop_count[%0d] got=%0d want=%0d", c, drop_count, m_drops); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_block_done();
`ifndef BRAM_WRITER_DROP_EN
    test_full();
`else
    test_drop();
`endif
    test_ptr_err();
    test_clear_handshake();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
